// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit arbiter.
//   tx_state_e : frame sequencer states
//   DATA_BITS  : payload bits per frame, sent LSB first
//   START_LVL  : line level of the start bit
//   STOP_LVL   : line level of the stop bit, gap and idle line
//   max_u      : larger of two unsigned values (counter sizing)
package serial_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StGap
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_LVL = 1'b0;
    localparam logic        STOP_LVL  = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk     : clock
//   reset   : synchronous active-high reset; pointer then favours requester 0
//   enable  : grants may only be issued while high
//   req     : request bits, index 0 and 1
//   gnt     : one-hot grant (combinational); any nonzero grant is an accept
//   gnt_idx : index of the granted requester (valid when gnt is nonzero)
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    // Index granted most recently; resets to 1 so requester 0 wins the first tie.
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (enable && !reset) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gnt_idx = gnt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Serial frame transmitter shared by two requesters.
// Frame: start bit, 8 data bits LSB first, optional even-parity bit, stop bit,
// then optional forced idle gap. Each bit lasts BIT_CYCLES clocks.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, abandons any frame in flight
//   req_valid  : frame request per requester (index 0 and 1)
//   req_data0  : byte offered by requester 0
//   req_data1  : byte offered by requester 1
//   req_ready  : one-hot accept strobe, only nonzero while idle
//   tx         : registered serial line, idle high
//   busy       : high from the cycle after accept until back in idle
//   gnt_id     : requester owning the current or most recent frame
//   frame_done : pulse on the last clock of the stop bit
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic       tx,
    output logic       busy,
    output logic       gnt_id,
    output logic       frame_done
);

    localparam int unsigned CNT_MAX = max_u(BIT_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             gnt_q, gnt_d;
    logic             tx_q, tx_d;

    logic       idle;
    logic [1:0] grant;
    logic       grant_idx;
    logic       accept;
    logic       bit_end;

    assign idle    = (state_q == StIdle);
    assign accept  = (grant != 2'b00);
    assign bit_end = (cnt_q == BIT_LAST);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .enable  (idle),
        .req     (req_valid),
        .gnt     (grant),
        .gnt_idx (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        gnt_d   = gnt_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    bit_d   = '0;
                    data_d  = grant_idx ? req_data1 : req_data0;
                    gnt_d   = grant_idx;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == IDX_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StParity: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES != 0) ? StGap : StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Line level follows the next state so tx changes on the same edge as the state.
        case (state_d)
            StStart:  tx_d = START_LVL;
            StData:   tx_d = data_q[bit_d];
            StParity: tx_d = ^data_q;
            default:  tx_d = STOP_LVL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            gnt_q   <= 1'b0;
            tx_q    <= STOP_LVL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            tx_q    <= tx_d;
        end
    end

    assign req_ready  = grant;
    assign tx         = tx_q;
    assign gnt_id     = gnt_q;
    assign busy       = !reset && !idle;
    assign frame_done = !reset && (state_q == StStop) && bit_end;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench: three instances (defaults; parity with 3 clocks/bit; 4-clock gap).
// Stimulus pushes the expected frame (owner, byte, accept spacing, optional literal
// waveform) when it raises a request; the monitor pops on each observed accept and
// checks the following frame cycle by cycle.
module tb_serial_tx_arbiter;

    logic clk;
    logic reset;
    logic [2:0][1:0] rv;
    logic [2:0][7:0] d0;
    logic [2:0][7:0] d1;
    logic [2:0][1:0] rr;
    logic [2:0]      txw;
    logic [2:0]      busyw;
    logic [2:0]      gidw;
    logic [2:0]      fdw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_tx_arbiter #(.BIT_CYCLES(1), .PARITY_EN(0), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_data0(d0[0]), .req_data1(d1[0]),
        .req_ready(rr[0]), .tx(txw[0]), .busy(busyw[0]), .gnt_id(gidw[0]), .frame_done(fdw[0])
    );

    serial_tx_arbiter #(.BIT_CYCLES(3), .PARITY_EN(1), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_data0(d0[1]), .req_data1(d1[1]),
        .req_ready(rr[1]), .tx(txw[1]), .busy(busyw[1]), .gnt_id(gidw[1]), .frame_done(fdw[1])
    );

    serial_tx_arbiter #(.BIT_CYCLES(1), .PARITY_EN(0), .GAP_CYCLES(4)) dut_c (
        .clk(clk), .reset(reset), .req_valid(rv[2]), .req_data0(d0[2]), .req_data1(d1[2]),
        .req_ready(rr[2]), .tx(txw[2]), .busy(busyw[2]), .gnt_id(gidw[2]), .frame_done(fdw[2])
    );

    typedef struct {
        int          dut;
        logic        gid;
        logic [7:0]  data;
        int          spacing;  // cycles since previous accept on this instance, <=0: unchecked
        logic [63:0] pat;      // literal tx waveform, bit i = cycle T+1+i
        int          pat_n;    // 0: no literal waveform
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    int bc_k[3]  = '{1, 3, 1};
    int par_k[3] = '{0, 1, 0};
    int gap_k[3] = '{0, 0, 4};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference line level at offset pos (0-based) after the accept cycle.
    function automatic logic exp_bit(input logic [7:0] d, input int par, input int pos,
                                     input int bc);
        int b;
        b = pos / bc;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par != 0 && b == 9) return ^d;
        return 1'b1;
    endfunction

    // Monitor state per instance.
    int          active[3];
    int          pos[3];
    int          last_acc[3];
    int          err[3];
    logic        cur_gid[3];
    logic [7:0]  cur_data[3];
    logic [63:0] got_b[3];
    logic [63:0] exp_b[3];
    logic [63:0] cur_pat[3];
    int          cur_pat_n[3];
    bit          chk_idle[3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            active[k]   = 0;
            chk_idle[k] = 0;
            last_acc[k] = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            int   flen;
            exp_t e;
            logic [63:0] mask;
            flen = (10 + par_k[k]) * bc_k[k];
            if (reset) begin
                active[k]   = 0;
                chk_idle[k] = 0;
            end else if (active[k] == 0) begin
                if (chk_idle[k]) begin
                    check($sformatf("busy_low_after_frame_dut%0d", k), 64'(busyw[k]), 64'd0);
                    chk_idle[k] = 0;
                end
                if ((rv[k] & rr[k]) != 2'b00) begin
                    if (sb.size() == 0) begin
                        check($sformatf("unexpected_accept_dut%0d", k), 64'(rr[k]), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("accept_dut_id_dut%0d", k), 64'(k), 64'(e.dut));
                        check($sformatf("req_ready_dut%0d", k), 64'(rr[k]),
                              e.gid ? 64'd2 : 64'd1);
                        if (e.spacing > 0) begin
                            check($sformatf("accept_spacing_dut%0d", k),
                                  64'(cyc - last_acc[k]), 64'(e.spacing));
                        end
                        last_acc[k]  = cyc;
                        active[k]    = 1;
                        pos[k]       = 0;
                        err[k]       = 0;
                        cur_gid[k]   = e.gid;
                        cur_data[k]  = e.data;
                        cur_pat[k]   = e.pat;
                        cur_pat_n[k] = e.pat_n;
                        got_b[k]     = '0;
                        exp_b[k]     = '0;
                    end
                end
            end else begin
                pos[k]++;
                if (pos[k] <= flen) begin
                    got_b[k][pos[k]-1] = txw[k];
                    exp_b[k][pos[k]-1] = exp_bit(cur_data[k], par_k[k], pos[k] - 1, bc_k[k]);
                    if (busyw[k] !== 1'b1 || gidw[k] !== cur_gid[k] ||
                        fdw[k] !== (pos[k] == flen)) begin
                        err[k]++;
                    end
                    if (pos[k] == flen) begin
                        check($sformatf("frame_bits_dut%0d_byte%02h", k, cur_data[k]),
                              got_b[k], exp_b[k]);
                        if (cur_pat_n[k] > 0) begin
                            mask = (64'd1 << cur_pat_n[k]) - 64'd1;
                            check($sformatf("frame_literal_dut%0d", k), got_b[k] & mask,
                                  cur_pat[k]);
                        end
                        check($sformatf("frame_ctl_errs_dut%0d", k), 64'(err[k]), 64'd0);
                        if (gap_k[k] == 0) begin
                            active[k]   = 0;
                            chk_idle[k] = 1;
                        end else begin
                            err[k] = 0;
                        end
                    end
                end else begin
                    if (txw[k] !== 1'b1 || busyw[k] !== 1'b1 || fdw[k] !== 1'b0) err[k]++;
                    if (pos[k] == flen + gap_k[k]) begin
                        check($sformatf("gap_errs_dut%0d", k), 64'(err[k]), 64'd0);
                        active[k]   = 0;
                        chk_idle[k] = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (sb.size() > n && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(sb.size()), 64'(n));
    endtask

    task automatic wait_idle(input string name, input int k, input int budget);
        int c;
        c = 0;
        while ((busyw[k] !== 1'b0 || active[k] != 0) && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(c < budget), 64'd1);
    endtask

    function automatic exp_t mk(input int dut, input logic gid, input logic [7:0] data,
                                input int spacing);
        exp_t e;
        e.dut     = dut;
        e.gid     = gid;
        e.data    = data;
        e.spacing = spacing;
        e.pat     = '0;
        e.pat_n   = 0;
        return e;
    endfunction

    initial begin
        exp_t e;
        reset = 1'b1;
        rv    = '0;
        d0    = '0;
        d1    = '0;

        // Reset state, with both requests raised: reset wins over an accept.
        tick();
        rv[0] = 2'b11;
        rv[1] = 2'b01;
        tick();
        tick();
        @(negedge clk);
        check("rst_req_ready_a", 64'(rr[0]), 64'd0);
        check("rst_req_ready_b", 64'(rr[1]), 64'd0);
        check("rst_tx_a", 64'(txw[0]), 64'd1);
        check("rst_busy_a", 64'(busyw[0]), 64'd0);
        check("rst_gnt_id_a", 64'(gidw[0]), 64'd0);
        check("rst_frame_done_a", 64'(fdw[0]), 64'd0);
        tick();
        rv    = '0;
        reset = 1'b0;
        tick();

        // 0xA5 from requester 0; literal waveform 0,1,0,1,0,0,1,0,1,1.
        d0[0] = 8'hA5;
        e = mk(0, 1'b0, 8'hA5, 0);
        e.pat   = 64'h34A;
        e.pat_n = 10;
        sb.push_back(e);
        rv[0] = 2'b01;
        tick();
        rv[0] = 2'b00;
        d0[0] = 8'h3C;  // must not disturb the frame already captured
        wait_idle("idle_after_a5", 0, 100);

        // Both requesters held: grants alternate 0,1,0,1 every 11 cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d0[0] = 8'h00;
        d1[0] = 8'hFF;
        sb.push_back(mk(0, 1'b0, 8'h00, 0));
        sb.push_back(mk(0, 1'b1, 8'hFF, 11));
        sb.push_back(mk(0, 1'b0, 8'h00, 11));
        sb.push_back(mk(0, 1'b1, 8'hFF, 11));
        rv[0] = 2'b11;
        wait_sb("rr_four_accepts", 0, 100);
        rv[0] = 2'b00;
        wait_idle("idle_after_rr", 0, 100);

        // Quiet line for 20 cycles, then a single-cycle request from requester 1.
        for (int i = 0; i < 20; i++) tick();
        check("quiet_busy", 64'(busyw[0]), 64'd0);
        d1[0] = 8'h5A;
        sb.push_back(mk(0, 1'b1, 8'h5A, 0));
        rv[0] = 2'b10;
        @(negedge clk);
        check("single_cycle_ready_10", 64'(rr[0]), 64'd2);
        tick();
        rv[0] = 2'b00;
        wait_idle("idle_after_5a", 0, 100);

        // Reset during data bit 3 of a requester-1 frame.
        d1[0] = 8'hC3;
        sb.push_back(mk(0, 1'b1, 8'hC3, 0));
        rv[0] = 2'b10;
        tick();
        rv[0] = 2'b00;
        repeat (4) tick();
        check("mid_frame_busy", 64'(busyw[0]), 64'd1);
        check("mid_frame_bit3", 64'(txw[0]), 64'd0);
        reset = 1'b1;
        rv[0] = 2'b11;
        d0[0] = 8'h81;
        tick();
        check("abort_tx_high", 64'(txw[0]), 64'd1);
        check("abort_busy_low", 64'(busyw[0]), 64'd0);
        check("abort_no_frame_done", 64'(fdw[0]), 64'd0);
        check("abort_gnt_id", 64'(gidw[0]), 64'd0);
        sb.push_back(mk(0, 1'b0, 8'h81, 0));
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_grant_0", 64'(rr[0]), 64'd1);
        tick();
        rv[0] = 2'b00;
        wait_idle("idle_after_81", 0, 100);

        // Parity, 3 clocks per bit: 0x07 (parity 1) then 0x03 (parity 0), 34 apart.
        d0[1] = 8'h07;
        sb.push_back(mk(1, 1'b0, 8'h07, 0));
        sb.push_back(mk(1, 1'b0, 8'h03, 34));
        rv[1] = 2'b01;
        wait_sb("parity_first_accept", 1, 100);
        d0[1] = 8'h03;
        wait_sb("parity_second_accept", 0, 100);
        rv[1] = 2'b00;
        wait_idle("idle_after_parity", 1, 100);

        // Four-clock gap: requester 0 held, accepts 15 apart.
        d0[2] = 8'h5A;
        sb.push_back(mk(2, 1'b0, 8'h5A, 0));
        sb.push_back(mk(2, 1'b0, 8'h5A, 15));
        sb.push_back(mk(2, 1'b0, 8'h5A, 15));
        rv[2] = 2'b01;
        wait_sb("gap_three_accepts", 0, 100);
        rv[2] = 2'b00;
        wait_idle("idle_after_gap", 2, 100);

        repeat (3) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
